bist_scheduler: RTL
===================

Name: bist_scheduler

Overview:
Round-robin scheduler that shares one BIST engine (BISTFSM) among NUM_REQ requesters. It arbitrates requests, issues a one-cycle BIST_Start, supervises BIST_Busy with start and run timeouts, and returns a per-requester completion pulse with the captured error code. It sits between the BIST requesters (per-lane control logic) and the single BISTFSM instance.

Parameters:
NUM_REQ, 4, number of requesters; range 2..8
BUSY_WAIT, 8, max cycles from BIST_Start to BIST_Busy rising
RUN_TIMEOUT, 1024, max cycles BIST_Busy may stay high
ERR_W, 3, width of BIST_Error

Ports:
ClK  in  1  clock; all logic on posedge
Clear  in  1  synchronous active-high reset
Req  in  NUM_REQ  level request per requester; held until that requester's Done
Grant  out  NUM_REQ  one-hot owner of the BIST engine; zero when idle
Done  out  NUM_REQ  one-cycle completion pulse to the granted requester
Err_Code  out  ERR_W  captured BIST_Error; valid only while Done != 0
Timeout_Flag  out  1  test aborted by timeout; valid only while Done != 0
Err_Log  out  NUM_REQ  sticky bit per requester: last result nonzero or timeout
BIST_Start  out  1  start pulse to the BIST engine
BIST_Busy  in  1  engine busy
BIST_Error  in  ERR_W  engine error code; stable once BIST_Busy falls
Sched_Busy  out  1  high in every state except S_IDLE

Behaviour:
- Reset (Clear=1 at posedge): state S_IDLE; Grant, Done, Err_Code, Timeout_Flag, Err_Log, BIST_Start, Sched_Busy = 0; counter = 0; RR pointer = requester 0 highest priority. Clear mid-test aborts without a Done pulse; the engine is not otherwise signalled.
- All outputs registered.
- S_IDLE: if Req != 0, the RR arbiter picks the first set bit at or after the pointer (wrapping). Next edge: Grant = one-hot winner, BIST_Start = 1, Sched_Busy = 1, -> S_START.
- S_START: lasts exactly 1 cycle. BIST_Start drops at the next edge; counter cleared; -> S_WAIT_BUSY.
- S_WAIT_BUSY: if BIST_Busy -> S_RUN, counter cleared. Else counter++. If the counter reaches BUSY_WAIT -> S_CAPTURE with timeout=1.
- S_RUN: if !BIST_Busy -> S_CAPTURE with timeout=0. Else counter++. If the counter reaches RUN_TIMEOUT -> S_CAPTURE with timeout=1.
- S_CAPTURE (1 cycle): at the next edge:
  - Done = Grant; Err_Code = timeout ? 0 : BIST_Error; Timeout_Flag = timeout.
  - Err_Log[winner] = timeout | (BIST_Error != 0). It is overwritten on each completion, not OR-accumulated.
  - Grant = 0; pointer = winner+1 mod NUM_REQ; -> S_IDLE.
- Done and Err_Code are zero in all other cycles.
- Latency: Req seen in S_IDLE at edge n gives Grant/BIST_Start at n+1. Done occurs 1 cycle after the edge at which Busy low is sampled in S_RUN.
- Minimum back-to-back gap: one S_IDLE cycle between Done and the next Grant.
- Req deasserted while granted: ignored; the test completes and Done still pulses.
- Req bits of non-granted requesters are sampled only in S_IDLE.
- BIST_Busy already high in S_IDLE: ignored. In S_WAIT_BUSY it is accepted immediately.
- Counter width: $clog2(max(BUSY_WAIT, RUN_TIMEOUT)+1). Saturation is not possible because the timeout transition exits the state first.

Decomposition:
- Package bist_sched_pkg:
  - sched_state_t enum: S_IDLE, S_START, S_WAIT_BUSY, S_RUN, S_CAPTURE.
  - ERR_W default constant.
  - Function for the counter width.
- Sub-module rr_arbiter (parameter N; inputs Req, Ptr; output one-hot Win), purely combinational. The scheduler registers its result.

Test Plan:
- Clear held 2 cycles, then Req=4'b0100; BFM raises Busy 2 cycles after Start and holds it 5 cycles with Error=3'b000 -> Grant=0100 one cycle after Req; BIST_Start is a single-cycle pulse; Done=0100 with Err_Code=0 and Timeout_Flag=0; Err_Log=0000.
- Req=4'b1111 continuously; each test runs 3 Busy cycles -> grant order 0001, 0010, 0100, 1000, 0001; exactly one S_IDLE cycle between each Done and the next Grant.
- BFM never raises Busy -> Done after BUSY_WAIT=8 wait cycles with Timeout_Flag=1 and Err_Code=0; Err_Log bit of the granted requester set.
- Busy held high permanently -> Done after RUN_TIMEOUT=1024 cycles in S_RUN with Timeout_Flag=1. Then a retest of the same requester with Error=0 clears its Err_Log bit.
- Test ends with BIST_Error=3'b101 -> Err_Code=101 for exactly the Done cycle; Err_Log bit set. Also drop Req mid-run -> Done still pulses.
- Assert Clear during S_RUN -> next edge: all outputs 0, no Done. The next Req=4'b0011 grants 0001 (pointer reset).

Source files
------------

// File: rtl/bist_sched_pkg.sv
// Shared types and helpers for the BIST scheduler: FSM state encoding and
// counter sizing.
package bist_sched_pkg;

  localparam int DEF_ERR_W = 3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_RUN       = 3'd3,
    S_CAPTURE   = 3'd4
  } sched_state_t;

  // One counter serves both the start wait and the run supervision.
  function automatic int cnt_width(input int busy_wait, input int run_timeout);
    int m;
    m = (busy_wait > run_timeout) ? busy_wait : run_timeout;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/bist_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after Ptr, wrapping.
// Win is one-hot, or zero when no request is set.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     Req,
  input  logic [PTR_W-1:0] Ptr,
  output logic [N-1:0]     Win
);

  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    Win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PTR_W'((int'(Ptr) + i) % N);
      if (!found && Req[idx]) begin
        Win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bist_scheduler.sv
// Shares one BIST engine among NUM_REQ requesters: round-robin grant, one-cycle
// start pulse, start/run timeouts, and a per-requester completion pulse.
module bist_scheduler
  import bist_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int BUSY_WAIT   = 8,
  parameter int RUN_TIMEOUT = 1024,
  parameter int ERR_W       = DEF_ERR_W
) (
  input  logic               ClK,
  input  logic               Clear,
  input  logic [NUM_REQ-1:0] Req,
  output logic [NUM_REQ-1:0] Grant,
  output logic [NUM_REQ-1:0] Done,
  output logic [ERR_W-1:0]   Err_Code,
  output logic               Timeout_Flag,
  output logic [NUM_REQ-1:0] Err_Log,
  output logic               BIST_Start,
  input  logic               BIST_Busy,
  input  logic [ERR_W-1:0]   BIST_Error,
  output logic               Sched_Busy,
  output sched_state_t       Sched_State
);

  // Handshake: a requester holds Req until it sees its Done pulse; Grant is
  // one-hot while a test is owned. Toward the engine, BIST_Start pulses one
  // cycle, the engine answers by raising BIST_Busy, and BIST_Error is taken
  // the cycle after Busy is seen low.
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = cnt_width(BUSY_WAIT, RUN_TIMEOUT);

  sched_state_t       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
  logic [PTR_W-1:0]   ptr_q, owner_q, win_idx;
  logic [NUM_REQ-1:0] win;
  logic               capture_err;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .Req (Req),
    .Ptr (ptr_q),
    .Win (win)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win[i]) win_idx = PTR_W'(i);
  end

  assign capture_err = timeout_q | (|BIST_Error);
  assign Sched_State = state_q;

  // Busy is checked before the counter so a response on the last allowed
  // cycle still counts as a start.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE:    if (|Req) state_d = S_START;
      S_START: begin
        state_d   = S_WAIT_BUSY;
        cnt_d     = '0;
        timeout_d = 1'b0;
      end
      S_WAIT_BUSY: begin
        if (BIST_Busy) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(BUSY_WAIT - 1)) begin
          state_d   = S_CAPTURE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (!BIST_Busy) begin
          state_d   = S_CAPTURE;
          timeout_d = 1'b0;
        end else if (cnt_q == CNT_W'(RUN_TIMEOUT - 1)) begin
          state_d   = S_CAPTURE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CAPTURE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ClK) begin
    if (Clear) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
      ptr_q        <= '0;
      owner_q      <= '0;
      Grant        <= '0;
      Done         <= '0;
      Err_Code     <= '0;
      Timeout_Flag <= 1'b0;
      Err_Log      <= '0;
      BIST_Start   <= 1'b0;
      Sched_Busy   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
      BIST_Start   <= (state_q == S_IDLE) && (|Req);
      Sched_Busy   <= (state_d != S_IDLE);
      Done         <= '0;
      Err_Code     <= '0;
      Timeout_Flag <= 1'b0;
      if ((state_q == S_IDLE) && (|Req)) begin
        Grant   <= win;
        owner_q <= win_idx;
      end
      // Err_Log keeps only the latest outcome of each requester.
      if (state_q == S_CAPTURE) begin
        Done         <= Grant;
        Err_Code     <= timeout_q ? '0 : BIST_Error;
        Timeout_Flag <= timeout_q;
        Err_Log      <= (Err_Log & ~Grant) | (capture_err ? Grant : '0);
        Grant        <= '0;
        ptr_q        <= (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
      end
    end
  end

endmodule
